// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Sequences and shares the per-channel rise/fall edge detectors of the TDC
// front end. It gates each detector's clock-enable by acquisition state and
// per-channel dead-time. It captures every detected edge with a coarse
// timestamp into a one-deep per-channel slot. It round-robin arbitrates the
// slots onto a single valid/ready event stream.
//
// Build option:
//   EDGE_ARB_DEADTIME_EN - when defined, each channel's detector stays
//                          disabled for DEAD_CYC cycles after a captured event.
//                          When undefined, no dead-time logic is built.
//
// Ports:
//   iClk, iRst      clock, asynchronous active-high reset
//   iStart, iStop   single-cycle acquisition start / stop-and-drain pulses
//   iRise, iFall    per-channel edge pulses from the detectors
//   oEnable         per-channel detector clock-enable (registered)
//   oValid, iReady  event stream handshake
//   oCh, oPol       channel index and polarity (1=rise) of the event
//   oTime           coarse timestamp of the event
//   oOverflow       sticky per-channel "event dropped" flags
//   oBusy           acquisition or drain in progress
//   oDone           one-cycle pulse when the drain completes
// ---------------------------------------------------------------------------

// Per-channel lane: pending slot, overflow flag and optional dead-time counter.
//   cap_en    edges are accepted (state is ARMED or DRAIN)
//   grant     slot is moved to the output register this cycle
//   ovf_clr   clear the sticky overflow flag
//   pending   slot holds an event; pol/stamp are its contents
//   quiet_nxt dead-time counter is zero in the next cycle
module edge_event_arbiter_lane #(
    parameter int COARSE_W = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap_en,
    input  logic                rise,
    input  logic                fall,
    input  logic                grant,
    input  logic                ovf_clr,
    input  logic [COARSE_W-1:0] coarse,
    output logic                pending,
    output logic                pol,
    output logic [COARSE_W-1:0] stamp,
    output logic                overflow,
    output logic                quiet_nxt
);
    logic hit;
    logic store;
    logic drop;

    assign hit   = cap_en & (rise | fall);
    // A slot being granted this cycle is free for the incoming edge.
    assign store = hit & (~pending | grant);
    assign drop  = hit & pending & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            pol     <= 1'b0;
            stamp   <= '0;
        end else if (store) begin
            pending <= 1'b1;
            pol     <= rise;        // rise wins when both pulse together
            stamp   <= coarse;
        end else if (grant) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overflow <= 1'b0;
        else if (ovf_clr) overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
    end

`ifdef EDGE_ARB_DEADTIME_EN
    logic [7:0] dead;
    logic [7:0] dead_nxt;

    always_comb begin
        dead_nxt = dead;
        if (store)
            dead_nxt = 8'(DEAD_CYC);
        else if (dead != 8'd0)
            dead_nxt = dead - 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dead <= 8'd0;
        else     dead <= dead_nxt;
    end

    assign quiet_nxt = (dead_nxt == 8'd0);
`else
    // Dead-time is not built; the parameter only keeps both builds' lists equal.
    logic dead_cyc_unused;
    assign dead_cyc_unused = (DEAD_CYC != 0);
    assign quiet_nxt       = 1'b1;
`endif
endmodule

module edge_event_arbiter #(
    parameter int N_CH     = 4,
    parameter int COARSE_W = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic                     iStop,
    input  logic [N_CH-1:0]          iRise,
    input  logic [N_CH-1:0]          iFall,
    output logic [N_CH-1:0]          oEnable,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [$clog2(N_CH)-1:0]  oCh,
    output logic                     oPol,
    output logic [COARSE_W-1:0]      oTime,
    output logic [N_CH-1:0]          oOverflow,
    output logic                     oBusy,
    output logic                     oDone
);
    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic   [COARSE_W-1:0]           coarse;

    logic   [N_CH-1:0]               slot_pending;
    logic   [N_CH-1:0]               slot_pol;
    logic   [N_CH-1:0][COARSE_W-1:0] slot_stamp;
    logic   [N_CH-1:0]               quiet_nxt;
    logic   [N_CH-1:0]               grant;

    logic                            out_valid;
    logic   [CH_W-1:0]               out_ch;
    logic                            out_pol;
    logic   [COARSE_W-1:0]           out_time;
    logic   [CH_W-1:0]               ptr;

    logic                            load;
    logic                            gnt_any;
    logic   [CH_W-1:0]               gnt_idx;
    logic                            cap_en;
    logic                            ovf_clr;

    logic   [N_CH-1:0]               enable_q;
    logic   [N_CH-1:0]               enable_nxt;
    logic                            done_q;
    logic                            done_nxt;

    assign cap_en  = (state != IDLE);
    assign ovf_clr = (state == IDLE) && iStart;

    // ---------------- per-channel lanes ----------------
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        edge_event_arbiter_lane #(
            .COARSE_W (COARSE_W),
            .DEAD_CYC (DEAD_CYC)
        ) u_lane (
            .clk       (iClk),
            .rst       (iRst),
            .cap_en    (cap_en),
            .rise      (iRise[i]),
            .fall      (iFall[i]),
            .grant     (grant[i]),
            .ovf_clr   (ovf_clr),
            .coarse    (coarse),
            .pending   (slot_pending[i]),
            .pol       (slot_pol[i]),
            .stamp     (slot_stamp[i]),
            .overflow  (oOverflow[i]),
            .quiet_nxt (quiet_nxt[i])
        );
    end

    // ---------------- round-robin grant ----------------
    // The output register can take a new event when empty or being drained
    // this cycle; iReady only affects the next-cycle state, never oValid.
    assign load = ~out_valid | iReady;

    always_comb begin
        int            c;
        logic [CH_W-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        c       = 0;
        cand    = '0;
        // Search starts one past the last granted channel.
        for (int k = 1; k <= N_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= N_CH) c = c - N_CH;
            cand = CH_W'(c);
            if (!gnt_any && slot_pending[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_CH; i++)
            grant[i] = load & gnt_any & (gnt_idx == CH_W'(i));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iStart) state_nxt = ARMED;
            ARMED:   if (iStop)  state_nxt = DRAIN;
            DRAIN:   if (slot_pending == '0 && !out_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Enables and done are computed from next-cycle state so the registered
    // outputs line up with the state they describe.
    always_comb begin
        enable_nxt = '0;
        if (state_nxt == ARMED) enable_nxt = quiet_nxt;
        done_nxt = (state == DRAIN) && (state_nxt == IDLE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            enable_q <= '0;
            done_q   <= 1'b0;
        end else begin
            enable_q <= enable_nxt;
            done_q   <= done_nxt;
        end
    end

    // ---------------- coarse timestamp ----------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                coarse <= '0;
        else if (ovf_clr)        coarse <= '0;
        else if (state == ARMED) coarse <= coarse + COARSE_W'(1);
    end

    // ---------------- output register ----------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_pol   <= 1'b0;
            out_time  <= '0;
            ptr       <= CH_W'(N_CH - 1);
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_ch   <= gnt_idx;
                out_pol  <= slot_pol[gnt_idx];
                out_time <= slot_stamp[gnt_idx];
                ptr      <= gnt_idx;
            end
        end
    end

    assign oEnable = enable_q;
    assign oValid  = out_valid;
    assign oCh     = out_ch;
    assign oPol    = out_pol;
    assign oTime   = out_time;
    assign oBusy   = (state != IDLE);
    assign oDone   = done_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Self-checking bench for edge_event_arbiter: a table of directed vectors with
// hand-derived expectations, hand sequences for overflow, drain, coarse wrap
// and mid-operation reset, and randomized traffic. Every cycle the DUT is
// also compared with a behavioural model of the arbiter's rules.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;
    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int DC  = 4;
    localparam int CHW = 2;

`ifdef EDGE_ARB_DEADTIME_EN
    localparam logic [N-1:0] T1_EN = 4'b1011;
    localparam logic [N-1:0] T2_EN = 4'b0100;
`else
    localparam logic [N-1:0] T1_EN = 4'b1111;
    localparam logic [N-1:0] T2_EN = 4'b1111;
`endif

    logic           iClk = 1'b0;
    logic           iRst, iStart, iStop, iReady;
    logic [N-1:0]   iRise, iFall;
    logic [N-1:0]   oEnable, oOverflow;
    logic           oValid, oPol, oBusy, oDone;
    logic [CHW-1:0] oCh;
    logic [CW-1:0]  oTime;

    always #5 iClk = ~iClk;

    edge_event_arbiter #(.N_CH(N), .COARSE_W(CW), .DEAD_CYC(DC)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop),
        .iRise(iRise), .iFall(iFall), .oEnable(oEnable), .oValid(oValid),
        .iReady(iReady), .oCh(oCh), .oPol(oPol), .oTime(oTime),
        .oOverflow(oOverflow), .oBusy(oBusy), .oDone(oDone)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st;                 // 0 idle, 1 armed, 2 drain
    int m_coarse;
    bit m_sv[N];              // slot occupied
    bit m_sp[N];
    int m_stt[N];
    bit m_ov[N];
    int m_dead[N];
    bit m_v;
    int m_ch, m_t, m_ptr;
    bit m_p, m_done;

    task automatic model_reset();
        m_st = 0; m_coarse = 0; m_v = 0; m_ch = 0; m_t = 0; m_p = 0;
        m_ptr = N - 1; m_done = 0;
        for (int i = 0; i < N; i++) begin
            m_sv[i] = 0; m_sp[i] = 0; m_stt[i] = 0; m_ov[i] = 0; m_dead[i] = 0;
        end
    endtask

    function automatic logic [N-1:0] m_en();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_st == 1) && (m_dead[i] == 0);
        return r;
    endfunction

    function automatic logic [N-1:0] m_ovm();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_ov[i];
        return r;
    endfunction

    task automatic model_step(input bit start, input bit stop, input logic [N-1:0] rise,
                              input logic [N-1:0] fall, input bit ready);
        bit load, anyp, old_v;
        int g, old_st, old_c;
        load = !m_v || ready;
        old_v = m_v; old_st = m_st; old_c = m_coarse;
        anyp = 0;
        for (int i = 0; i < N; i++) anyp |= m_sv[i];
        g = -1;
        if (load)
            for (int k = 1; k <= N; k++)
                if (g < 0 && m_sv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (load) begin
            m_v = (g >= 0);
            if (g >= 0) begin
                m_ch = g; m_p = m_sp[g]; m_t = m_stt[g]; m_ptr = g; m_sv[g] = 0;
            end
        end
        for (int i = 0; i < N; i++) if (m_dead[i] > 0) m_dead[i]--;
        // A slot freed by the grant above is free for a same-cycle edge.
        for (int i = 0; i < N; i++)
            if (old_st != 0 && (rise[i] || fall[i])) begin
                if (!m_sv[i]) begin
                    m_sv[i] = 1; m_sp[i] = rise[i]; m_stt[i] = old_c;
`ifdef EDGE_ARB_DEADTIME_EN
                    m_dead[i] = DC;
`endif
                end else m_ov[i] = 1;
            end
        m_done = 0;
        case (old_st)
            0: if (start) begin
                m_st = 1; m_coarse = 0;
                for (int i = 0; i < N; i++) m_ov[i] = 0;
            end
            1: begin
                m_coarse = (m_coarse + 1) % (1 << CW);
                if (stop) m_st = 2;
            end
            default: if (!anyp && !old_v) begin m_st = 0; m_done = 1; end
        endcase
    endtask

    task automatic check_all();
        chk("enable", 32'(oEnable), 32'(m_en()));
        chk("valid", 32'(oValid), 32'(m_v));
        if (m_v) begin
            chk("ch", 32'(oCh), 32'(m_ch));
            chk("pol", 32'(oPol), 32'(m_p));
            chk("time", 32'(oTime), 32'(m_t));
        end
        chk("overflow", 32'(oOverflow), 32'(m_ovm()));
        chk("busy", 32'(oBusy), 32'(m_st != 0));
        chk("done", 32'(oDone), 32'(m_done));
    endtask

    int dut_q[$];             // timestamps of accepted beats, seen at the DUT

    task automatic cyc(input bit start, input bit stop, input logic [N-1:0] rise,
                       input logic [N-1:0] fall, input bit ready);
        iStart = start; iStop = stop; iRise = rise; iFall = fall; iReady = ready;
        #1;
        if (oValid && ready) dut_q.push_back(int'(oTime));
        @(posedge iClk);
        model_step(start, stop, rise, fall, ready);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        iStart = 0; iStop = 0; iRise = '0; iFall = '0; iReady = 0;
        iRst = 1;
        #1;
        model_reset();
        check_all();
        @(posedge iClk);
        #1;
        iRst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           rst;
        bit           start;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        bit           ready;
        bit           e_v;
        int           e_ch;
        bit           e_p;
        int           e_t;
        logic [N-1:0] e_en;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int rdy_pct;
        logic [N-1:0] r, f, en;

        // T1: ch2 rise captured at coarse 10, single beat, 4-cycle dead-time.
        tbl.push_back('{1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        tbl.push_back('{0, 0, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, T1_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 1, 2, 1, 10, T1_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, T1_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, T1_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        // T2: same-cycle falls on ch0/1/3 -> three beats in channel order.
        tbl.push_back('{1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        tbl.push_back('{0, 0, 4'b0000, 4'b1011, 1, 0, 0, 0, 0, T2_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0, 1, T2_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 1, 1, 0, 1, T2_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 1, 3, 0, 1, T2_EN});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b1111});

        iRst = 1; iStart = 0; iStop = 0; iRise = '0; iFall = '0; iReady = 0;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cyc(tbl[i].start, 0, tbl[i].rise, tbl[i].fall, tbl[i].ready);
            chk("tbl_valid", 32'(oValid), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                chk("tbl_ch", 32'(oCh), 32'(tbl[i].e_ch));
                chk("tbl_pol", 32'(oPol), 32'(tbl[i].e_p));
                chk("tbl_time", 32'(oTime), 32'(tbl[i].e_t));
            end
            chk("tbl_enable", 32'(oEnable), 32'(tbl[i].e_en));
        end

        // T3: back-pressure, slot full -> overflow; exactly two beats delivered.
        do_reset();
        cyc(1, 0, '0, '0, 0);
        cyc(0, 0, '0, '0, 0);
        cyc(0, 0, 4'b0010, '0, 0);
        repeat (5) cyc(0, 0, '0, '0, 0);
        cyc(0, 0, 4'b0010, '0, 0);
        repeat (5) cyc(0, 0, '0, '0, 0);
        cyc(0, 0, '0, 4'b0010, 0);
        cyc(0, 0, '0, '0, 0);
        chk("ovf_set", 32'(oOverflow), 32'h2);
        dut_q.delete();
        repeat (6) cyc(0, 0, '0, '0, 1);
        chk("ovf_beats", dut_q.size(), 2);
        cyc(0, 1, '0, '0, 1);
        for (int i = 0; i < 20 && !oDone; i++) cyc(0, 0, '0, '0, 1);
        chk("ovf_drained_idle", 32'(oBusy), 0);
        chk("ovf_still_set", 32'(oOverflow), 32'h2);
        cyc(1, 0, '0, '0, 1);
        chk("ovf_clr_by_start", 32'(oOverflow), 0);

        // T4: stop with two events pending, ready toggling.
        do_reset();
        cyc(1, 0, '0, '0, 0);
        cyc(0, 0, '0, '0, 0);
        cyc(0, 0, 4'b0001, 4'b0100, 0);
        cyc(0, 1, '0, '0, 0);
        chk("drain_enable_off", 32'(oEnable), 0);
        dut_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, '0, '0, bit'(i % 2));
            if (oDone) begin
                done_cnt++;
                chk("drain_busy_at_done", 32'(oBusy), 0);
            end
        end
        chk("drain_done_pulses", done_cnt, 1);
        chk("drain_beats", dut_q.size(), 2);

        // T5: coarse wrap, timestamps 65535 then 0.
        do_reset();
        cyc(1, 0, '0, '0, 1);
        for (int i = 0; i < 70000 && m_coarse != 65535; i++) cyc(0, 0, '0, '0, 1);
        dut_q.delete();
        cyc(0, 0, 4'b0001, '0, 1);
        cyc(0, 0, '0, 4'b0010, 1);
        repeat (4) cyc(0, 0, '0, '0, 1);
        chk("wrap_beats", dut_q.size(), 2);
        if (dut_q.size() == 2) begin
            chk("wrap_t0", dut_q[0], 65535);
            chk("wrap_t1", dut_q[1], 0);
        end

        // T6: asynchronous reset while an event is held on the output.
        do_reset();
        cyc(1, 0, '0, '0, 0);
        cyc(0, 0, 4'b1000, '0, 0);
        cyc(0, 0, '0, '0, 0);
        cyc(0, 0, '0, '0, 0);
        chk("pre_rst_valid", 32'(oValid), 1);
        #2;
        iRst = 1;
        #1;
        model_reset();
        chk("rst_enable", 32'(oEnable), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_ch", 32'(oCh), 0);
        chk("rst_pol", 32'(oPol), 0);
        chk("rst_time", 32'(oTime), 0);
        chk("rst_overflow", 32'(oOverflow), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_done", 32'(oDone), 0);
        @(posedge iClk);
        #1;
        iRst = 0;
        cyc(1, 0, '0, '0, 0);
        cyc(0, 0, 4'b0001, '0, 0);
        cyc(0, 0, '0, '0, 0);
        chk("restart_valid", 32'(oValid), 1);
        chk("restart_time", 32'(oTime), 0);
        chk("restart_ch", 32'(oCh), 0);

        // Random traffic against the model.
        do_reset();
        rdy_pct = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 100;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 10;
                endcase
            end
            en = m_en();
            r = '0; f = '0;
            for (int i = 0; i < N; i++)
                if (en[i] && $urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       r[i] = 1'b1;
                        1:       f[i] = 1'b1;
                        default: begin r[i] = 1'b1; f[i] = 1'b1; end
                    endcase
                end
            cyc(bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 149) == 0),
                r, f, bit'($urandom_range(0, 99) < rdy_pct));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
